// File: rtl/axi4_if.sv
// AXI4 bus bundle shared by the RAM slave and its masters.
// Widths are set per instance; the *user fields are carried but not interpreted by the slave.
interface axi4_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic [USER_WIDTH-1:0] awuser;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [StrbWidth-1:0]  wstrb;
  logic                  wlast;
  logic [USER_WIDTH-1:0] wuser;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic [USER_WIDTH-1:0] buser;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic [USER_WIDTH-1:0] aruser;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [USER_WIDTH-1:0] ruser;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_ram_slave.sv
// AXI4 slave over a word RAM with independent read and write FSMs, one transaction each.
// Out-of-range or unsupported-burst beats are consumed and answered with SLVERR.
module axi4_ram_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input logic   aclk,
  input logic   areset,
  axi4_if.slave axi
);
  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned OffW  = (Bytes > 1) ? $clog2(Bytes) : 0;
  localparam int unsigned MemAw = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdFetch, RdData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ID_WIDTH-1:0]   wr_id_q, rd_id_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q, rd_idx_q;
  logic [7:0]            wr_len_q, rd_len_q, wr_cnt_q, rd_cnt_q;
  logic                  wr_fixed_q, rd_fixed_q, wr_legal_q, rd_legal_q;
  logic                  wr_err_q, rd_ok_q;
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic aw_hs, w_hs, ar_hs, r_hs, aw_legal, ar_legal, wr_in_range, rd_in_range, mem_we;

  assign aw_hs = axi.awvalid && (wr_state_q == WrIdle);
  assign w_hs  = axi.wvalid && (wr_state_q == WrData);
  assign ar_hs = axi.arvalid && (rd_state_q == RdIdle);
  assign r_hs  = axi.rready && (rd_state_q == RdData);

  assign aw_legal = (axi.awburst == 2'b00 || axi.awburst == 2'b01) && axi.awsize == 3'(OffW);
  assign ar_legal = (axi.arburst == 2'b00 || axi.arburst == 2'b01) && axi.arsize == 3'(OffW);
  assign wr_in_range = 32'(wr_idx_q) < MEM_WORDS;
  assign rd_in_range = 32'(rd_idx_q) < MEM_WORDS;
  assign mem_we = w_hs && wr_legal_q && wr_in_range && !areset;

  // Write FSM
  always_ff @(posedge aclk) begin
    if (areset) wr_state_q <= WrIdle;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WrIdle:  if (axi.awvalid) wr_state_d = WrData;
      WrData:  if (axi.wvalid && axi.wlast) wr_state_d = WrResp;
      WrResp:  if (axi.bready) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    axi.awready = (wr_state_q == WrIdle);
    axi.wready  = (wr_state_q == WrData);
    axi.bvalid  = (wr_state_q == WrResp);
    axi.bresp   = (wr_state_q == WrResp && wr_err_q) ? 2'b10 : 2'b00;
    axi.bid     = wr_id_q;
    axi.buser   = '0;
  end

  // Length mismatch shows up as wlast disagreeing with the expected final beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_fixed_q <= 1'b0;
      wr_legal_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else if (aw_hs) begin
      wr_id_q    <= axi.awid;
      wr_idx_q   <= ADDR_WIDTH'(axi.awaddr >> OffW);
      wr_len_q   <= axi.awlen;
      wr_cnt_q   <= '0;
      wr_fixed_q <= (axi.awburst == 2'b00);
      wr_legal_q <= aw_legal;
      wr_err_q   <= !aw_legal;
    end else if (w_hs) begin
      wr_cnt_q <= wr_cnt_q + 8'd1;
      if (!wr_fixed_q) wr_idx_q <= wr_idx_q + ADDR_WIDTH'(1);
      if (!wr_in_range || (axi.wlast != (wr_cnt_q == wr_len_q))) wr_err_q <= 1'b1;
    end
  end

  // RAM: byte-enabled write port, registered read port (read-before-write on collisions).
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (axi.wstrb[b]) mem[wr_idx_q[MemAw-1:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
      end
    end
    if (rd_state_q == RdFetch) rd_word_q <= mem[rd_idx_q[MemAw-1:0]];
  end

  // Read FSM
  always_ff @(posedge aclk) begin
    if (areset) rd_state_q <= RdIdle;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle:  if (axi.arvalid) rd_state_d = RdFetch;
      RdFetch: rd_state_d = RdData;
      RdData:  if (axi.rready) rd_state_d = (rd_cnt_q == rd_len_q) ? RdIdle : RdFetch;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    axi.arready = (rd_state_q == RdIdle);
    axi.rvalid  = (rd_state_q == RdData);
    axi.rdata   = rd_ok_q ? rd_word_q : '0;
    axi.rresp   = (rd_state_q == RdData && !rd_ok_q) ? 2'b10 : 2'b00;
    axi.rlast   = (rd_state_q == RdData) && (rd_cnt_q == rd_len_q);
    axi.rid     = rd_id_q;
    axi.ruser   = '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_fixed_q <= 1'b0;
      rd_legal_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else if (ar_hs) begin
      rd_id_q    <= axi.arid;
      rd_idx_q   <= ADDR_WIDTH'(axi.araddr >> OffW);
      rd_len_q   <= axi.arlen;
      rd_cnt_q   <= '0;
      rd_fixed_q <= (axi.arburst == 2'b00);
      rd_legal_q <= ar_legal;
    end else if (rd_state_q == RdFetch) begin
      rd_ok_q <= rd_legal_q && rd_in_range;
    end else if (r_hs && (rd_cnt_q != rd_len_q)) begin
      rd_cnt_q <= rd_cnt_q + 8'd1;
      if (!rd_fixed_q) rd_idx_q <= rd_idx_q + ADDR_WIDTH'(1);
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion,
                         axi.awuser, axi.wuser, axi.arlock, axi.arcache, axi.arprot,
                         axi.arqos, axi.arregion, axi.aruser};
endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed bench for axi4_ram_slave: bursts, strobes, range/legality errors, back-pressure
// with concurrent traffic, and reset in the middle of a read burst.
module tb_axi4_ram_slave;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned IW = 1;
  localparam int unsigned MW = 1024;
  localparam int Timeout = 200;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(1)) axi ();

  axi4_ram_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ID_WIDTH  (IW),
    .MEM_WORDS (MW)
  ) dut (
    .aclk  (clk),
    .areset(areset),
    .axi   (axi.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wd [256];
  logic [3:0]    ws [256];
  logic [DW-1:0] rd_d [256];
  logic [1:0]    rd_r [256];
  logic          rd_l [256];
  logic [IW-1:0] rd_id, b_id;
  logic [1:0]    b_resp;
  logic          b_early, b_held, r_unstable;
  int            r_lat, r_gap, bstall, rstall;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_master();
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = 2'b01;
    axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0; axi.awregion = '0;
    axi.awuser = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wuser = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = 2'b01;
    axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0; axi.arregion = '0;
    axi.aruser = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int nbeats);
    int n;
    int k;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst;
    axi.awvalid = 1'b1;
    n = 0;
    while (axi.awready !== 1'b1 && n < Timeout) begin tick(); n++; end
    if (n >= Timeout) begin errors++; $display("FAIL aw_wait got awready=0 want awready=1"); end
    tick();
    axi.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = (i == nbeats - 1); axi.wvalid = 1'b1;
      n = 0;
      while (axi.wready !== 1'b1 && n < Timeout) begin tick(); n++; end
      if (n >= Timeout) begin errors++; $display("FAIL w_wait got wready=0 want wready=1"); end
      tick();
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    b_early = axi.bvalid;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < Timeout) begin tick(); n++; end
    if (n >= Timeout) begin errors++; $display("FAIL b_wait got bvalid=0 want bvalid=1"); end
    b_resp = axi.bresp;
    b_id = axi.bid;
    b_held = 1'b1;
    k = (bstall > 0) ? int'($urandom_range(0, bstall)) : 0;
    repeat (k) begin
      tick();
      if (axi.bvalid !== 1'b1 || axi.bresp !== b_resp || axi.bid !== b_id) b_held = 1'b0;
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    int n;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst;
    axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < Timeout) begin tick(); n++; end
    if (n >= Timeout) begin errors++; $display("FAIL ar_wait got arready=0 want arready=1"); end
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n;
    int k;
    logic [DW-1:0] d0;
    logic [1:0] r0;
    logic l0;
    issue_ar(id, addr, len, size, burst);
    r_unstable = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (axi.rvalid !== 1'b1 && n < Timeout) begin tick(); n++; end
      if (n >= Timeout) begin errors++; $display("FAIL r_wait got rvalid=0 want rvalid=1"); end
      if (i == 0) r_lat = n + 1;
      if (i == 1) r_gap = n + 1;
      d0 = axi.rdata; r0 = axi.rresp; l0 = axi.rlast;
      rd_d[i] = d0; rd_r[i] = r0; rd_l[i] = l0; rd_id = axi.rid;
      k = (rstall > 0) ? int'($urandom_range(0, rstall)) : 0;
      repeat (k) begin
        tick();
        if (axi.rvalid !== 1'b1 || axi.rdata !== d0 || axi.rresp !== r0 || axi.rlast !== l0)
          r_unstable = 1'b1;
      end
      axi.rready = 1'b1;
      tick();
      axi.rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    init_master();
    areset = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    got = {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast,
           axi.bresp, axi.rresp, axi.bid, axi.rid};
    checks++;
    if (got !== 12'b1100_0000_0000) begin
      errors++; $display("FAIL reset_outputs got %b want 110000000000", got);
    end
    checks++;
    if ({axi.buser, axi.ruser} !== 2'b00) begin
      errors++; $display("FAIL reset_user got %b want 00", {axi.buser, axi.ruser});
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0A0_0000 | i; ws[i] = 4'hF; end
    do_write(1'b1, 16'h0010, 8'd3, 3'd2, 2'b01, 4);
    checks++;
    if (b_resp !== 2'b00 || b_id !== 1'b1) begin
      errors++; $display("FAIL incr_b got resp=%b id=%b want resp=00 id=1", b_resp, b_id);
    end
    checks++;
    if (b_early !== 1'b1) begin
      errors++; $display("FAIL incr_b_latency got bvalid=%b want 1 after wlast", b_early);
    end
    do_read(1'b1, 16'h0010, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_d[i] !== (32'hA0A0_0000 | i) || rd_r[i] !== 2'b00 || rd_l[i] !== (i == 3)) begin
        errors++;
        $display("FAIL incr_beat%0d got d=%h r=%b l=%b want d=%h r=00 l=%b", i, rd_d[i],
                 rd_r[i], rd_l[i], 32'hA0A0_0000 | i, i == 3);
      end
    end
    checks++;
    if (rd_id !== 1'b1) begin errors++; $display("FAIL incr_rid got %b want 1", rd_id); end
    checks++;
    if (r_lat !== 2 || r_gap !== 2) begin
      errors++; $display("FAIL read_timing got lat=%0d gap=%0d want lat=2 gap=2", r_lat, r_gap);
    end
  endtask

  task automatic test_strobe();
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(1'b0, 16'h0000, 8'd0, 3'd2, 2'b01, 1);
    wd[0] = 32'h0000_1234; ws[0] = 4'b0011;
    do_write(1'b0, 16'h0000, 8'd0, 3'd2, 2'b01, 1);
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0000;
    do_write(1'b0, 16'h0000, 8'd0, 3'd2, 2'b01, 1);
    do_read(1'b0, 16'h0000, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'hDEAD_1234 || rd_r[0] !== 2'b00 || rd_l[0] !== 1'b1) begin
      errors++;
      $display("FAIL strobe got d=%h r=%b l=%b want d=dead1234 r=00 l=1", rd_d[0], rd_r[0],
               rd_l[0]);
    end
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(1'b0, 16'h0020, 8'd2, 3'd2, 2'b00, 3);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL fixed_b got %b want 00", b_resp); end
    do_read(1'b0, 16'h0020, 8'd1, 3'd2, 2'b00);
    checks++;
    if (rd_d[0] !== 32'd3 || rd_d[1] !== 32'd3 || rd_l[0] !== 1'b0 || rd_l[1] !== 1'b1) begin
      errors++;
      $display("FAIL fixed_read got %h,%h last=%b%b want 3,3 last=01", rd_d[0], rd_d[1],
               rd_l[0], rd_l[1]);
    end
  endtask

  task automatic test_out_of_range();
    wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
    do_write(1'b0, 16'h0FFC, 8'd0, 3'd2, 2'b01, 1);
    do_read(1'b0, 16'h0FFC, 8'd1, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'h5555_AAAA || rd_r[0] !== 2'b00) begin
      errors++; $display("FAIL oor_beat0 got d=%h r=%b want 5555aaaa 00", rd_d[0], rd_r[0]);
    end
    checks++;
    if (rd_d[1] !== 32'h0 || rd_r[1] !== 2'b10 || rd_l[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_beat1 got d=%h r=%b l=%b want 0 10 1", rd_d[1], rd_r[1], rd_l[1]);
    end
    wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(1'b1, 16'h0FFC, 8'd1, 3'd2, 2'b01, 2);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL oor_write got %b want 10", b_resp); end
    do_read(1'b0, 16'h0FFC, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'h1111_2222) begin
      errors++; $display("FAIL oor_last_word got %h want 11112222", rd_d[0]);
    end
  endtask

  task automatic test_illegal();
    wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hEEEE_EEEE; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(1'b0, 16'h0010, 8'd1, 3'd1, 2'b01, 2);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL bad_size got %b want 10", b_resp); end
    do_write(1'b0, 16'h0014, 8'd1, 3'd2, 2'b10, 2);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL wrap_write got %b want 10", b_resp); end
    do_read(1'b0, 16'h0010, 8'd1, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'hA0A0_0000 || rd_d[1] !== 32'hA0A0_0001) begin
      errors++;
      $display("FAIL illegal_unchanged got %h,%h want a0a00000,a0a00001", rd_d[0], rd_d[1]);
    end
    do_read(1'b1, 16'h0010, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_d[i] !== 32'h0 || rd_r[i] !== 2'b10 || rd_l[i] !== (i == 2)) begin
        errors++;
        $display("FAIL wrap_read%0d got d=%h r=%b l=%b want 0 10 %b", i, rd_d[i], rd_r[i],
                 rd_l[i], i == 2);
      end
    end
  endtask

  task automatic test_len_mismatch();
    wd[0] = 32'h0000_4040; wd[1] = 32'h0000_4444; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(1'b0, 16'h0040, 8'd3, 3'd2, 2'b01, 2);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL short_burst got %b want 10", b_resp); end
    do_write(1'b0, 16'h0050, 8'd0, 3'd2, 2'b01, 2);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL long_burst got %b want 10", b_resp); end
    do_read(1'b0, 16'h0040, 8'd1, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'h0000_4040 || rd_d[1] !== 32'h0000_4444) begin
      errors++; $display("FAIL short_data got %h,%h want 4040,4444", rd_d[0], rd_d[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0B0_0000 | i; ws[i] = 4'hF; end
    bstall = 3;
    rstall = 3;
    fork
      do_write(1'b0, 16'h0100, 8'd3, 3'd2, 2'b01, 4);
      do_read(1'b1, 16'h0010, 8'd3, 3'd2, 2'b01);
    join
    checks++;
    if (r_unstable !== 1'b0 || b_held !== 1'b1) begin
      errors++; $display("FAIL stall_stable got r_unstable=%b b_held=%b want 0 1", r_unstable,
                         b_held);
    end
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL conc_b got %b want 00", b_resp); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_d[i] !== (32'hA0A0_0000 | i) || rd_l[i] !== (i == 3)) begin
        errors++; $display("FAIL conc_read%0d got %h l=%b want %h l=%b", i, rd_d[i], rd_l[i],
                           32'hA0A0_0000 | i, i == 3);
      end
    end
    do_read(1'b0, 16'h0100, 8'd3, 3'd2, 2'b01);
    bstall = 0;
    rstall = 0;
    checks++;
    if (rd_d[0] !== 32'hB0B0_0000 || rd_d[3] !== 32'hB0B0_0003 || r_unstable !== 1'b0) begin
      errors++; $display("FAIL conc_write got %h,%h want b0b00000,b0b00003", rd_d[0], rd_d[3]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    wd[0] = 32'hC0C0_0000; wd[1] = 32'hC0C0_0001; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(1'b0, 16'h0200, 8'd1, 3'd2, 2'b01, 2);
    issue_ar(1'b1, 16'h0200, 8'd7, 3'd2, 2'b01);
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (axi.rvalid !== 1'b1 && n < Timeout) begin tick(); n++; end
      if (n >= Timeout) begin errors++; $display("FAIL mid_wait got rvalid=0 want 1"); end
      if (b == 0) begin
        checks++;
        if (axi.rdata !== 32'hC0C0_0000) begin
          errors++; $display("FAIL mid_beat0 got %h want c0c00000", axi.rdata);
        end
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
      end
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1 || axi.rlast !== 1'b0) begin
      errors++; $display("FAIL mid_reset got rvalid=%b arready=%b rlast=%b want 0 1 0",
                         axi.rvalid, axi.arready, axi.rlast);
    end
    repeat (3) tick();
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_no_resume got rvalid=%b want 0", axi.rvalid);
    end
    do_read(1'b0, 16'h0200, 8'd1, 3'd2, 2'b01);
    checks++;
    if (rd_d[0] !== 32'hC0C0_0000 || rd_d[1] !== 32'hC0C0_0001) begin
      errors++; $display("FAIL mid_retained got %h,%h want c0c00000,c0c00001", rd_d[0], rd_d[1]);
    end
  endtask

  initial begin
    bstall = 0;
    rstall = 0;
    test_reset();
    test_incr();
    test_strobe();
    test_fixed();
    test_out_of_range();
    test_illegal();
    test_len_mismatch();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before 1000000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
